// File: rtl/ibuf_load_ctrl.sv
// Input-tile load sequencer: one AXI-style read burst per feature-map row,
// opens the buffer write window while loading, then holds the tile resident
// until the compute scheduler releases it.
module ibuf_load_ctrl #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned STRIDE  = 1,
  parameter int unsigned POY     = 3,
  parameter int unsigned POX     = 3,
  parameter int unsigned KSIZE   = 3,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [AW-1:0] cfg_base,
  input  logic [AW-1:0] cfg_pitch,
  output logic          arvalid,
  input  logic          arready,
  output logic [AW-1:0] araddr,
  output logic [7:0]    arlen,
  input  logic          rvalid,
  input  logic          rlast,
  output logic          rready,
  output logic          data_load,
  output logic          buf_valid,
  input  logic          buf_release,
  output logic          busy,
  output logic          len_err
);

  localparam int unsigned LM   = (STRIDE + 1) * POY - STRIDE;
  localparam int unsigned BUFW = POX * STRIDE + KSIZE / 2;
  localparam int unsigned CW   = $clog2(LM + 1);
  localparam int unsigned OW   = 4;
  localparam int unsigned BW   = 8;

  // Reject parameter sets the counters cannot represent.
  if ((DW % 8) != 0 || MAX_OUT < 1 || MAX_OUT > 15) begin : g_param_check
    $error("ibuf_load_ctrl: DW must be a byte multiple and MAX_OUT within 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic [AW-1:0] pitch_q, pitch_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] done_rows_q, done_rows_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          arvalid_q, arvalid_d;
  logic          len_err_q, len_err_d;
  logic          cfg_ready_q, cfg_ready_d;
  logic          data_load_q, data_load_d;
  logic          rready_q, rready_d;
  logic          buf_valid_q, buf_valid_d;
  logic          busy_q, busy_d;

  logic ar_hs;
  logic r_hs;
  logic rlast_hs;

  assign ar_hs    = arvalid_q & arready;
  assign r_hs     = rvalid & rready_q;
  assign rlast_hs = r_hs & rlast;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d       = state_q;
    araddr_d      = araddr_q;
    pitch_d       = pitch_q;
    issued_d      = issued_q;
    done_rows_d   = done_rows_q;
    outstanding_d = outstanding_q;
    beat_cnt_d    = beat_cnt_q;
    arvalid_d     = 1'b0;
    len_err_d     = len_err_q;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          araddr_d      = cfg_base;
          pitch_d       = cfg_pitch;
          issued_d      = '0;
          done_rows_d   = '0;
          outstanding_d = '0;
          beat_cnt_d    = '0;
          arvalid_d     = 1'b1;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        if (ar_hs) begin
          issued_d = issued_q + CW'(1);
          araddr_d = araddr_q + pitch_q;
        end
        if (r_hs) begin
          if (rlast) begin
            beat_cnt_d  = '0;
            done_rows_d = done_rows_q + CW'(1);
            if (beat_cnt_q != BW'(BUFW - 1)) begin
              len_err_d = 1'b1;
            end
          end else if (beat_cnt_q != {BW{1'b1}}) begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end
        outstanding_d = outstanding_q + OW'(ar_hs) - OW'(rlast_hs);
        if (rlast_hs && (done_rows_d == CW'(LM))) begin
          state_d = DONE;
        end else begin
          arvalid_d = (issued_d < CW'(LM)) && (outstanding_d < OW'(MAX_OUT));
        end
      end
      DONE: begin
        if (buf_release) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cfg_ready_d = (state_d == IDLE);
    data_load_d = (state_d == LOAD);
    rready_d    = (state_d == LOAD);
    buf_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State, counters and output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      araddr_q      <= '0;
      pitch_q       <= '0;
      issued_q      <= '0;
      done_rows_q   <= '0;
      outstanding_q <= '0;
      beat_cnt_q    <= '0;
      arvalid_q     <= 1'b0;
      len_err_q     <= 1'b0;
      cfg_ready_q   <= 1'b1;
      data_load_q   <= 1'b0;
      rready_q      <= 1'b0;
      buf_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      araddr_q      <= araddr_d;
      pitch_q       <= pitch_d;
      issued_q      <= issued_d;
      done_rows_q   <= done_rows_d;
      outstanding_q <= outstanding_d;
      beat_cnt_q    <= beat_cnt_d;
      arvalid_q     <= arvalid_d;
      len_err_q     <= len_err_d;
      cfg_ready_q   <= cfg_ready_d;
      data_load_q   <= data_load_d;
      rready_q      <= rready_d;
      buf_valid_q   <= buf_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arlen     = 8'(BUFW - 1);
  assign rready    = rready_q;
  assign data_load = data_load_q;
  assign buf_valid = buf_valid_q;
  assign busy      = busy_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_ibuf_load_ctrl.sv
// Scoreboard bench for ibuf_load_ctrl: expected AR addresses and tile
// completions are queued at cfg time and checked by a negedge monitor.
module tb_ibuf_load_ctrl;

  localparam int LM = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_base = '0;
  logic [31:0] cfg_pitch = '0;
  logic        arvalid;
  logic        arready = 1'b1;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        rvalid = 1'b0;
  logic        rlast = 1'b0;
  logic        rready;
  logic        data_load;
  logic        buf_valid;
  logic        buf_release = 1'b0;
  logic        busy;
  logic        len_err;

  ibuf_load_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_base(cfg_base), .cfg_pitch(cfg_pitch),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .data_load(data_load), .buf_valid(buf_valid), .buf_release(buf_release),
    .busy(busy), .len_err(len_err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_addr_q[$];
  int          done_q[$];
  int          b_start[$];
  int          b_beats[$];
  int          beat = 0;

  int ar_n = 0, rl_n = 0, stall_seen = 0;
  int ar_cyc[8];
  int rl_cyc = 0, rl1_cyc = 0, cfg_cyc = 0;
  int r_delay = 2, short_idx = -1, stall_idx = -1, stall_left = 0;
  int exp_le;
  logic bv_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: R bursts in AR order, plus AR backpressure injection.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      b_start.delete();
      b_beats.delete();
      beat = 0;
      rvalid = 1'b0;
      rlast = 1'b0;
    end else if (b_start.size() != 0 && b_start[0] <= cyc) begin
      rvalid = 1'b1;
      rlast = (beat == b_beats[0] - 1);
      if (rlast) begin
        beat = 0;
        void'(b_start.pop_front());
        void'(b_beats.pop_front());
      end else begin
        beat++;
      end
    end else begin
      rvalid = 1'b0;
      rlast = 1'b0;
    end
    if (arvalid && ar_n == stall_idx && stall_left > 0) begin
      arready = 1'b0;
      stall_left--;
    end else begin
      arready = 1'b1;
    end
  end

  // Monitor: pops expected addresses on AR activity and completions on buf_valid rise.
  always @(negedge clk) begin
    if (rst) begin
      bv_prev = 1'b0;
    end else begin
      if (arvalid) begin
        if (exp_addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ar_unexpected: got araddr 0x%0h with nothing expected (cycle %0d)", araddr, cyc);
        end else begin
          chk("araddr", 64'(araddr), 64'(exp_addr_q[0]));
          if (arready) begin
            chk("arlen", 64'(arlen), 64'd3);
            if (ar_n < 8) ar_cyc[ar_n] = cyc;
            b_start.push_back(cyc + r_delay);
            b_beats.push_back((ar_n == short_idx) ? 3 : 4);
            void'(exp_addr_q.pop_front());
            ar_n++;
          end else begin
            stall_seen++;
          end
        end
      end
      if (rvalid && rready && rlast) begin
        rl_n++;
        rl_cyc = cyc;
        if (rl_n == 1) rl1_cyc = cyc;
      end
      if (buf_valid && !bv_prev) begin
        if (done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL buf_valid_unexpected: got buf_valid=1 with no load pending (cycle %0d)", cyc);
        end else begin
          exp_le = done_q.pop_front();
          chk("len_err_at_done", 64'(len_err), 64'(exp_le));
          chk("buf_valid_latency", 64'(cyc), 64'(rl_cyc + 1));
          chk("rows_done", 64'(rl_n), 64'(LM));
          chk("ar_count", 64'(ar_n), 64'(LM));
          chk("data_load_in_done", 64'(data_load), 64'd0);
          chk("rready_in_done", 64'(rready), 64'd0);
        end
      end
      bv_prev = buf_valid;
    end
  end

  task automatic do_cfg(input logic [31:0] base, input logic [31:0] pitch, input int exp_len);
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_base = base;
    cfg_pitch = pitch;
    ar_n = 0;
    rl_n = 0;
    stall_seen = 0;
    for (int i = 0; i < LM; i++) exp_addr_q.push_back(base + pitch * 32'(i));
    done_q.push_back(exp_len);
    @(negedge clk);
    chk("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    cfg_cyc = cyc;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("data_load_start", 64'(data_load), 64'd1);
    chk("arvalid_start", 64'(arvalid), 64'd1);
    chk("rready_start", 64'(rready), 64'd1);
    chk("busy_load", 64'(busy), 64'd1);
    chk("cfg_ready_load", 64'(cfg_ready), 64'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!buf_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 64'(buf_valid), 64'd1);
  endtask

  task automatic wait_rlast(input int cnt);
    int n = 0;
    while (rl_n < cnt && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    chk("rlast_count_reached", 64'(rl_n >= cnt), 64'd1);
  endtask

  task automatic do_release();
    @(posedge clk); #1;
    buf_release = 1'b1;
    @(negedge clk);
    chk("buf_valid_before_release", 64'(buf_valid), 64'd1);
    @(posedge clk); #1;
    buf_release = 1'b0;
    @(negedge clk);
    chk("buf_valid_after_release", 64'(buf_valid), 64'd0);
    chk("cfg_ready_after_release", 64'(cfg_ready), 64'd1);
    chk("busy_after_release", 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_data_load", 64'(data_load), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_buf_valid", 64'(buf_valid), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("arlen_const", 64'(arlen), 64'd3);

    // Basic load with zero-wait memory.
    do_cfg(32'h1000, 32'h100, 0);
    wait_done();
    chk("ar0_latency", 64'(ar_cyc[0]), 64'(cfg_cyc + 1));
    chk("ar1_latency", 64'(ar_cyc[1]), 64'(cfg_cyc + 2));
    chk("len_err_basic", 64'(len_err), 64'd0);
    do_release();

    // Outstanding limit with slow R responses.
    r_delay = 20;
    do_cfg(32'h2000, 32'h40, 0);
    repeat (14) @(negedge clk);
    chk("ar_outstanding_limit", 64'(ar_n), 64'd2);
    chk("arvalid_while_limited", 64'(arvalid), 64'd0);
    wait_done();
    chk("ar2_after_first_rlast", 64'(ar_cyc[2]), 64'(rl1_cyc + 1));
    do_release();

    // AR backpressure on the second burst.
    r_delay = 2;
    stall_idx = 1;
    stall_left = 7;
    do_cfg(32'h1000, 32'h100, 0);
    wait_done();
    chk("ar_stall_cycles", 64'(stall_seen), 64'd7);
    stall_idx = -1;

    // Tile held in DONE; cfg ignored until released.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cfg_valid = (i == 4);
      cfg_base = 32'hdead_0000;
      @(negedge clk);
      chk("buf_valid_hold", 64'(buf_valid), 64'd1);
      chk("cfg_ready_in_done", 64'(cfg_ready), 64'd0);
    end
    do_release();

    // Short third burst sets the sticky length error.
    short_idx = 2;
    do_cfg(32'h8000, 32'h20, 1);
    wait_rlast(3);
    @(negedge clk);
    chk("len_err_set", 64'(len_err), 64'd1);
    wait_done();
    short_idx = -1;
    do_release();
    chk("len_err_sticky", 64'(len_err), 64'd1);

    // Reset in the middle of a load.
    do_cfg(32'h4000, 32'h100, 0);
    wait_rlast(2);
    rst = 1'b1;
    exp_addr_q.delete();
    done_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_data_load", 64'(data_load), 64'd0);
    chk("mid_rst_arvalid", 64'(arvalid), 64'd0);
    chk("mid_rst_rready", 64'(rready), 64'd0);
    chk("mid_rst_buf_valid", 64'(buf_valid), 64'd0);
    chk("mid_rst_len_err", 64'(len_err), 64'd0);
    chk("mid_rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("mid_rst_araddr", 64'(araddr), 64'd0);
    rst = 1'b0;
    do_cfg(32'h5000, 32'h80, 0);
    wait_done();
    chk("len_err_after_reload", 64'(len_err), 64'd0);
    do_release();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_addr_q.size() + done_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
